// File: rtl/fmul_pkg.sv
// Shared types and derived-constant helpers for the pipelined FP multiplier.
package fmul_pkg;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  // Width-independent special-case summary carried down the pipe with each op.
  typedef struct packed {
    logic      sign;
    fp_class_e cls;
  } fp_kind_t;

  function automatic int unsigned bit_w(input int unsigned exp_w, input int unsigned m_w);
    return 32'd1 + exp_w + m_w;
  endfunction

  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned exp_max(input int unsigned exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

  // Class of the product, resolved with NaN > inf > zero precedence.
  function automatic fp_class_e combine_cls(input fp_class_e a, input fp_class_e b);
    if (a == FP_NAN || b == FP_NAN ||
        (a == FP_INF && b == FP_ZERO) || (a == FP_ZERO && b == FP_INF)) return FP_NAN;
    if (a == FP_INF || b == FP_INF) return FP_INF;
    if (a == FP_ZERO || b == FP_ZERO) return FP_ZERO;
    return FP_NORM;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier; denormals are treated as zero.
module fp_classify
  import fmul_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned M_W   = 23
) (
  input  logic [EXP_W-1:0] exp_i,
  input  logic [M_W-1:0]   man_i,
  output fp_class_e        cls_c
);

  always_comb begin
    cls_c = FP_NORM;
    if (exp_i == '0) begin
      cls_c = FP_ZERO;
    end else if (&exp_i) begin
      cls_c = (man_i == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage floating-point multiplier with valid/ready flow control and tag passthrough.
// Build option FMUL_PIPE_RNE_EN selects round-to-nearest-even; default build truncates.
module fmul_pipe
  import fmul_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned M_W   = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+M_W:0]   a_in,
  input  logic [EXP_W+M_W:0]   b_in,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+M_W:0]   result,
  output logic [TAG_W-1:0]     tag_out,
  output logic                 flag_ovf,
  output logic                 flag_unf
);

  localparam int unsigned BIT_W   = bit_w(EXP_W, M_W);
  localparam int unsigned BIAS    = bias(EXP_W);
  localparam int unsigned EXP_MAX = exp_max(EXP_W);
  localparam int unsigned SEW     = EXP_W + 2;
  localparam int unsigned PW      = 2 * (M_W + 1);

  typedef struct packed {
    logic             valid;
    fp_kind_t         kind;
    logic [SEW-1:0]   exp;
    logic [PW-1:0]    prod;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             valid;
    fp_kind_t         kind;
    logic [SEW-1:0]   exp;
    logic [M_W-1:0]   frac;
`ifdef FMUL_PIPE_RNE_EN
    logic             guard;
    logic             sticky;
`endif
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic             valid;
    logic [BIT_W-1:0] res;
    logic [TAG_W-1:0] tag;
    logic             ovf;
    logic             unf;
  } s3_t;

  s1_t            s1_d, s1_q;
  s2_t            s2_d, s2_q;
  s3_t            s3_d, s3_q;
  logic           adv_c;
  fp_class_e      cls_a_c, cls_b_c;
  logic [M_W:0]   mant_r_c;
  logic [SEW-1:0] exp_r_c;

  // Whole pipe moves together; a stalled output freezes every stage.
  assign adv_c    = ~s3_q.valid | out_ready;
  assign in_ready = adv_c;

  fp_classify #(.EXP_W(EXP_W), .M_W(M_W)) u_cls_a (
    .exp_i (a_in[M_W +: EXP_W]),
    .man_i (a_in[M_W-1:0]),
    .cls_c (cls_a_c)
  );

  fp_classify #(.EXP_W(EXP_W), .M_W(M_W)) u_cls_b (
    .exp_i (b_in[M_W +: EXP_W]),
    .man_i (b_in[M_W-1:0]),
    .cls_c (cls_b_c)
  );

  // Stage 1: classify, sign, biased exponent sum, full mantissa product.
  always_comb begin
    s1_d           = '0;
    s1_d.valid     = in_valid;
    s1_d.kind.sign = a_in[BIT_W-1] ^ b_in[BIT_W-1];
    s1_d.kind.cls  = combine_cls(cls_a_c, cls_b_c);
    s1_d.exp       = SEW'(a_in[M_W +: EXP_W]) + SEW'(b_in[M_W +: EXP_W]) - SEW'(BIAS);
    s1_d.prod      = PW'({1'b1, a_in[M_W-1:0]}) * PW'({1'b1, b_in[M_W-1:0]});
    s1_d.tag       = tag_in;
  end

  // Stage 2: product lies in [1,4); normalise to [1,2) and split off G/S.
  always_comb begin
    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.kind  = s1_q.kind;
    s2_d.tag   = s1_q.tag;
    s2_d.exp   = s1_q.exp + SEW'(s1_q.prod[PW-1]);
    if (s1_q.prod[PW-1]) begin
      s2_d.frac   = s1_q.prod[PW-2 -: M_W];
`ifdef FMUL_PIPE_RNE_EN
      s2_d.guard  = s1_q.prod[PW-2-M_W];
      s2_d.sticky = |s1_q.prod[PW-3-M_W:0];
`endif
    end else begin
      s2_d.frac   = s1_q.prod[PW-3 -: M_W];
`ifdef FMUL_PIPE_RNE_EN
      s2_d.guard  = s1_q.prod[PW-3-M_W];
      s2_d.sticky = |s1_q.prod[PW-4-M_W:0];
`endif
    end
  end

`ifdef FMUL_PIPE_RNE_EN
  assign mant_r_c = {1'b0, s2_q.frac} + (M_W+1)'(s2_q.guard & (s2_q.sticky | s2_q.frac[0]));
`else
  logic unused_lsb_c;
  assign unused_lsb_c = ^s1_q.prod[M_W-1:0];
  assign mant_r_c     = {1'b0, s2_q.frac};
`endif

  // Rounding carry turns 1.11..1 into 10.0; fraction is already zero then.
  assign exp_r_c = s2_q.exp + SEW'(mant_r_c[M_W]);

  // Stage 3: special values first, then exponent range, then normal pack.
  always_comb begin
    s3_d       = '0;
    s3_d.valid = s2_q.valid;
    s3_d.tag   = s2_q.tag;
    if (s2_q.kind.cls == FP_NAN) begin
      s3_d.res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(M_W-1){1'b0}}};
    end else if (s2_q.kind.cls == FP_INF) begin
      s3_d.res = {s2_q.kind.sign, {EXP_W{1'b1}}, {M_W{1'b0}}};
    end else if (s2_q.kind.cls == FP_ZERO) begin
      s3_d.res = {s2_q.kind.sign, {(BIT_W-1){1'b0}}};
    end else if (!exp_r_c[SEW-1] && (exp_r_c >= SEW'(EXP_MAX))) begin
      s3_d.res = {s2_q.kind.sign, {EXP_W{1'b1}}, {M_W{1'b0}}};
      s3_d.ovf = 1'b1;
    end else if (exp_r_c[SEW-1] || (exp_r_c == '0)) begin
      s3_d.res = {s2_q.kind.sign, {(BIT_W-1){1'b0}}};
      s3_d.unf = 1'b1;
    end else begin
      s3_d.res = {s2_q.kind.sign, exp_r_c[EXP_W-1:0], mant_r_c[M_W-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (adv_c) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign out_valid = s3_q.valid;
  assign result    = s3_q.res;
  assign tag_out   = s3_q.tag;
  assign flag_ovf  = s3_q.ovf;
  assign flag_unf  = s3_q.unf;

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe (fp32); reference model uses real arithmetic.
module tb_fmul_pipe;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  tag;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  tag_out;
  logic        flag_ovf;
  logic        flag_unf;

  exp_t        exp_q[$];
  exp_t        drv_exp;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_out   = 0;
  logic        rand_ready = 1'b0;
  logic        stall_prev = 1'b0;
  logic [37:0] held;

  fmul_pipe #(.EXP_W(8), .M_W(23), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .tag_out   (tag_out),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic [3:0] t, input logic o, input logic u);
    exp_t e;
    e.r = r; e.tag = t; e.ovf = o; e.unf = u;
    return e;
  endfunction

  // Exact value of a normal fp32 operand as a double (sign dropped).
  function automatic real to_real(input logic [31:0] x);
    logic [63:0] d;
    d = {1'b0, 11'(32'(x[30:23]) + 32'd896), x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    exp_t        e;
    logic        sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [63:0] pb;
    logic [23:0] m;
    int          ex;
    e      = mk(32'h0, t, 1'b0, 1'b0);
    sign   = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      e.r = 32'h7FC00000;
    end else if (a_inf || b_inf) begin
      e.r = {sign, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      e.r = {sign, 31'h0};
    end else begin
      // 24x24-bit significand product fits a double exactly.
      pb = $realtobits(to_real(a) * to_real(b));
      ex = int'(pb[62:52]) - 896;
      m  = {1'b0, pb[51:29]};
`ifdef FMUL_PIPE_RNE_EN
      if (pb[28] && ((|pb[27:0]) || m[0])) m = m + 24'd1;
`endif
      if (m[23]) ex = ex + 1;
      if (ex >= 255) begin
        e.r = {sign, 8'hFF, 23'h0};
        e.ovf = 1'b1;
      end else if (ex <= 0) begin
        e.r = {sign, 31'h0};
        e.unf = 1'b1;
      end else begin
        e.r = {sign, 8'(ex), m[22:0]};
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] m;
    int          k;
    k = int'($urandom_range(0, 11));
    m = 23'($urandom);
    case (k)
      0:       e = 8'h00;
      1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = 23'h0; end
      2, 3:    e = 8'($urandom_range(1, 20));
      4, 5:    e = 8'($urandom_range(230, 254));
      6:       begin e = 8'($urandom_range(100, 154)); m = 23'h7FFFFF - 23'($urandom_range(0, 3)); end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, m};
  endfunction

  // Record expectation at the sampling edge preceding each transfer.
  initial forever begin
    @(negedge clk);
    if (rst_n && in_valid && in_ready) exp_q.push_back(drv_exp);
  end

  // Monitor: handshake rule, hold-under-stall, in-order result checks.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (stall_prev) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", 64'({result, tag_out, flag_ovf, flag_unf}), 64'(held));
      end
      stall_prev = out_valid && !out_ready;
      held = {result, tag_out, flag_ovf, flag_unf};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got result %h tag %0d, want no output", result, tag_out);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          check("result", 64'(result), 64'(e.r));
          check("tag", 64'(tag_out), 64'(e.tag));
          check("flags", 64'({flag_ovf, flag_unf}), 64'({e.ovf, e.unf}));
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Present one op and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t, input exp_t e);
    int k;
    in_valid = 1'b1; a_in = a; b_in = b; tag_in = t; drv_exp = e;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 200) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: in_ready stuck at 0, want 1");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    send(a, b, t, ref_mul(a, b, t));
  endtask

  task automatic drain();
    int k;
    k = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  initial begin
    int lat, out0;
    logic [31:0] ra, rb;
    rst_n = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; tag_in = '0; out_ready = 1'b1;
    drv_exp = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_outputs", 64'({result, tag_out, flag_ovf, flag_unf}), 64'(0));
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_idle_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;

    // Basic op plus latency measurement.
    send(32'h3FC00000, 32'h40000000, 4'd5, mk(32'h40400000, 4'd5, 1'b0, 1'b0));
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(3));
    drain();

`ifdef FMUL_PIPE_RNE_EN
    send(32'h3F800001, 32'h40400000, 4'd1, mk(32'h40400002, 4'd1, 1'b0, 1'b0));
`else
    send(32'h3F800001, 32'h40400000, 4'd1, mk(32'h40400001, 4'd1, 1'b0, 1'b0));
`endif
    send(32'h7F000000, 32'h7F000000, 4'd2, mk(32'h7F800000, 4'd2, 1'b1, 1'b0));
    send(32'h00800000, 32'h00800000, 4'd3, mk(32'h00000000, 4'd3, 1'b0, 1'b1));
    send(32'h80000000, 32'h3F800000, 4'd4, mk(32'h80000000, 4'd4, 1'b0, 1'b0));
    send(32'h7F800000, 32'h00000000, 4'd6, mk(32'h7FC00000, 4'd6, 1'b0, 1'b0));
    send(32'hFF800000, 32'h40000000, 4'd7, mk(32'hFF800000, 4'd7, 1'b0, 1'b0));
    send(32'h7FC12345, 32'h3F800000, 4'd8, mk(32'h7FC00000, 4'd8, 1'b0, 1'b0));
    drain();

    // Back-pressure: six ops, output stalled during cycles 4..8.
    out0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send_m(32'h3F800000 + 32'(i), 32'h40000000 + 32'(i << 20), 4'(i));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 64'(n_out - out0), 64'(6));

    // Randomised traffic with random output stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = rand_op();
      rb = rand_op();
      send_m(ra, rb, 4'(i));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    // Asynchronous reset with ops in flight and a result on the output.
    for (int i = 0; i < 5; i++) send_m(32'h3FC00000, 32'h3FC00000 + 32'(i), 4'(9 + i));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_data", 64'({result, tag_out, flag_ovf, flag_unf}), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_valid", 64'(out_valid), 64'(0));
      check("post_rst_ready", 64'(in_ready), 64'(1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
